// File: rtl/inst_imm_encoder.sv
// RV32I instruction encoder: packs opcode/register/funct fields and an immediate into a 32-bit word,
// with a 2-entry elastic output buffer and statistics counters. INST_IMM_ENC_RANGE_CHK_EN enables immediate legality checks.
module inst_imm_encoder #(
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_inst,
   output logic             out_err,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] enc_cnt,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_BAD
   } fmt_t;

   fmt_t        w_fmt;
   logic [31:0] w_inst;
   logic        w_err;
   logic        w_push;
   logic        w_pop;

   logic [1:0]  r_count;
   logic [31:0] r_ent0_inst;
   logic        r_ent0_err;
   logic [31:0] r_ent1_inst;
   logic        r_ent1_err;
   logic [CNT_W-1:0] r_enc_cnt;
   logic [ERR_W-1:0] r_err_cnt;

   always_comb begin
      unique case (in_opcode[6:2])
         5'b01100:                   w_fmt = FMT_R;
         5'b00100, 5'b11001, 5'b00000: w_fmt = FMT_I;
         5'b01000:                   w_fmt = FMT_S;
         5'b11000:                   w_fmt = FMT_B;
         5'b01101, 5'b00101:         w_fmt = FMT_U;
         5'b11011:                   w_fmt = FMT_J;
         default:                    w_fmt = FMT_BAD;
      endcase
   end

`ifdef INST_IMM_ENC_RANGE_CHK_EN
   // Sign-extension checks: the bits above each field must all be copies of the field's top bit.
   logic w_fit_is;
   logic w_fit_b;
   logic w_fit_j;
   logic w_fit_u;

   assign w_fit_is = (&in_imm[31:11]) | ~(|in_imm[31:11]);
   assign w_fit_b  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
   assign w_fit_j  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
   assign w_fit_u  = ~(|in_imm[11:0]);
`endif

   always_comb begin
      w_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      w_err  = 1'b0;
      unique case (w_fmt)
         FMT_R: begin
            w_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         end
         FMT_I: begin
            w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
`ifdef INST_IMM_ENC_RANGE_CHK_EN
            w_err  = ~w_fit_is;
`endif
         end
         FMT_S: begin
            w_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
`ifdef INST_IMM_ENC_RANGE_CHK_EN
            w_err  = ~w_fit_is;
`endif
         end
         FMT_B: begin
            w_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], in_opcode};
`ifdef INST_IMM_ENC_RANGE_CHK_EN
            w_err  = ~w_fit_b;
`endif
         end
         FMT_U: begin
            w_inst = {in_imm[31:12], in_rd, in_opcode};
`ifdef INST_IMM_ENC_RANGE_CHK_EN
            w_err  = ~w_fit_u;
`endif
         end
         FMT_J: begin
            w_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
`ifdef INST_IMM_ENC_RANGE_CHK_EN
            w_err  = ~w_fit_j;
`endif
         end
         default: begin
            w_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            w_err  = 1'b1;
         end
      endcase
   end

   // Ready depends only on the registered fill level, never on out_ready.
   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign out_inst  = r_ent0_inst;
   assign out_err   = r_ent0_err;
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count     <= 2'd0;
         r_ent0_inst <= 32'd0;
         r_ent0_err  <= 1'b0;
         r_ent1_inst <= 32'd0;
         r_ent1_err  <= 1'b0;
      end else begin
         unique case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_ent0_inst <= w_inst;
                  r_ent0_err  <= w_err;
               end else begin
                  r_ent1_inst <= w_inst;
                  r_ent1_err  <= w_err;
               end
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               if (r_count == 2'd2) begin
                  r_ent0_inst <= r_ent1_inst;
                  r_ent0_err  <= r_ent1_err;
               end
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               // Simultaneous push and pop is only possible with exactly one entry held.
               r_ent0_inst <= w_inst;
               r_ent0_err  <= w_err;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_enc_cnt <= '0;
         r_err_cnt <= '0;
      end else if (cnt_clr) begin
         r_enc_cnt <= '0;
         r_err_cnt <= '0;
      end else if (w_pop) begin
         r_enc_cnt <= r_enc_cnt + CNT_W'(1);
         if (r_ent0_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
         end
      end
   end

   assign enc_cnt = r_enc_cnt;
   assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_inst_imm_encoder.sv
// Testbench for inst_imm_encoder: directed vector table, backpressure/reset/saturation sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_inst_imm_encoder;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;
   logic        cnt_clr;
   logic [15:0] enc_cnt;
   logic [7:0]  err_cnt;

   inst_imm_encoder #(.CNT_W(16), .ERR_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_err(out_err),
      .cnt_clr(cnt_clr), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
   );

`ifdef INST_IMM_ENC_RANGE_CHK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp_inst;
      logic        exp_err;
   } vec_t;

   vec_t vecs[8];
   logic [32:0] q[$];
   logic [15:0] m_enc;
   logic [7:0]  m_err;
   int checks = 0;
   int failures = 0;
   bit mon_en = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] at(input logic [31:0] v, input int p);
      return v << p;
   endfunction

   // Reference: fields placed by shift/mask arithmetic, legality by signed numeric range.
   function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [4:0] rd,
         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
         input logic [6:0] f7, input logic [31:0] imm);
      longint si;
      bit even;
      logic [31:0] w;
      bit e;
      si = longint'($signed(imm));
      even = (imm % 2) == 0;
      e = 1'b0;
      w = at(f7, 25) | at(rs2, 20) | at(rs1, 15) | at(f3, 12) | at(rd, 7) | 32'(op);
      case (int'(op) / 4)
         12: ;
         4, 25, 0: begin
            w = at(imm & 32'hFFF, 20) | at(rs1, 15) | at(f3, 12) | at(rd, 7) | 32'(op);
            e = RC && (si < -2048 || si > 2047);
         end
         8: begin
            w = at((imm >> 5) & 32'h7F, 25) | at(rs2, 20) | at(rs1, 15) | at(f3, 12)
              | at(imm & 32'h1F, 7) | 32'(op);
            e = RC && (si < -2048 || si > 2047);
         end
         24: begin
            w = at((imm >> 12) & 1, 31) | at((imm >> 5) & 32'h3F, 25) | at(rs2, 20)
              | at(rs1, 15) | at(f3, 12) | at((imm >> 1) & 32'hF, 8)
              | at((imm >> 11) & 1, 7) | 32'(op);
            e = RC && (si < -4096 || si > 4095 || !even);
         end
         13, 5: begin
            w = (imm & 32'hFFFFF000) | at(rd, 7) | 32'(op);
            e = RC && ((imm % 4096) != 0);
         end
         27: begin
            w = at((imm >> 20) & 1, 31) | at((imm >> 1) & 32'h3FF, 21)
              | at((imm >> 11) & 1, 20) | at((imm >> 12) & 32'hFF, 12) | at(rd, 7) | 32'(op);
            e = RC && (si < -1048576 || si > 1048575 || !even);
         end
         default: e = 1'b1;
      endcase
      return {e, w};
   endfunction

   // Scoreboard: inputs are stable around negedge, so evaluate the upcoming edge's handshakes here.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         chk("out_valid_lvl", 64'(out_valid), 64'(q.size() != 0));
         chk("in_ready_lvl", 64'(in_ready), 64'(q.size() != 2));
         chk("enc_cnt", 64'(enc_cnt), 64'(m_enc));
         chk("err_cnt", 64'(err_cnt), 64'(m_err));
         if (out_valid && out_ready && q.size() != 0) begin
            chk("sb_word", {31'd0, out_err, out_inst}, 64'(q[0]));
            if (!cnt_clr) begin
               m_enc = m_enc + 16'd1;
               if (q[0][32] && m_err != 8'hFF) m_err = m_err + 8'd1;
            end
            void'(q.pop_front());
         end
         if (cnt_clr) begin
            m_enc = 16'd0;
            m_err = 8'd0;
         end
         if (in_valid && in_ready)
            q.push_back(ref_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input vec_t v);
      in_opcode = v.op;
      in_rd     = v.rd;
      in_rs1    = v.rs1;
      in_rs2    = v.rs2;
      in_funct3 = v.f3;
      in_funct7 = v.f7;
      in_imm    = v.imm;
   endtask

   function automatic logic [31:0] rand_imm();
      case ($urandom_range(0, 4))
         0: return $urandom;
         1: return 32'($urandom_range(0, 8191)) - 32'd4096;
         2: return $urandom & 32'hFFFFF000;
         3: return 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
         default: return 32'($urandom_range(0, 4095)) & 32'hFFFFFFFE;
      endcase
   endfunction

   initial begin
      logic [6:0] ops[12];
      vec_t vb;
      ops = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0B, 7'h57};

      vecs[0] = '{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0};
      vecs[1] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000008, 32'h00208463, 1'b0};
      vecs[2] = '{7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000003, 32'h00208163, RC};
      vecs[3] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0};
      vecs[4] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123452B7, RC};
      vecs[5] = '{7'h7F, 5'd3, 5'd4, 5'd5, 3'd6, 7'h20, 32'h0000ABCD, 32'h405261FF, 1'b1};
      vecs[6] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0};
      vecs[7] = '{7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFE312E23, 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
      set_req(vecs[0]);
      m_enc = 16'd0; m_err = 8'd0;
      tick(); tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_inst", 64'(out_inst), 64'd0);
      chk("rst_counters", {enc_cnt, err_cnt}, 64'd0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      tick();

      // Directed table: one request at a time, output expected the cycle after acceptance.
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_req(vecs[i]);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("vec%0d_inst", i), 64'(out_inst), 64'(vecs[i].exp_inst));
         chk($sformatf("vec%0d_err", i), 64'(out_err), 64'(vecs[i].exp_err));
         tick();
         if (i == 0) chk("enc_after_addi", 64'(enc_cnt), 64'd1);
      end

      // Backpressure: two accepted, third stalls until the first pop frees a slot.
      out_ready = 1'b0;
      set_req(vecs[0]); in_valid = 1'b1; tick();
      set_req(vecs[1]); tick();
      set_req(vecs[3]);
      chk("bp_full", 64'(in_ready), 64'd0);
      tick();
      chk("bp_still_full", 64'(in_ready), 64'd0);
      chk("bp_hold", 64'(out_inst), 64'(vecs[0].exp_inst));
      out_ready = 1'b1;
      tick();
      chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
      chk("bp_second", 64'(out_inst), 64'(vecs[1].exp_inst));
      tick();
      in_valid = 1'b0;
      chk("bp_third", 64'(out_inst), 64'(vecs[3].exp_inst));
      tick();
      chk("bp_drained", 64'(out_valid), 64'd0);

      // Saturation of err_cnt with 256 unsupported-opcode words, then a clear during a pop.
      set_req(vecs[5]); in_valid = 1'b1;
      repeat (256) tick();
      in_valid = 1'b0;
      tick();
      chk("err_sat", 64'(err_cnt), 64'hFF);
      in_valid = 1'b1;
      tick();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      in_valid = 1'b0;
      chk("clr_enc", 64'(enc_cnt), 64'd0);
      chk("clr_err", 64'(err_cnt), 64'd0);
      tick();

      // Asynchronous reset while the buffer is full.
      out_ready = 1'b0;
      set_req(vecs[6]); in_valid = 1'b1; tick();
      set_req(vecs[7]); tick();
      in_valid = 1'b0;
      chk("pre_rst_full", 64'(in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      q.delete();
      m_enc = 16'd0; m_err = 8'd0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      chk("arst_out_inst", 64'(out_inst), 64'd0);
      chk("arst_counters", {enc_cnt, err_cnt}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      set_req(vecs[3]); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("post_rst_lat", 64'(out_valid), 64'd1);
      chk("post_rst_inst", 64'(out_inst), 64'(vecs[3].exp_inst));
      tick();

      // Randomized traffic against the reference model.
      for (int c = 0; c < 600; c++) begin
         vb.op  = ($urandom_range(0, 15) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
         vb.rd  = 5'($urandom); vb.rs1 = 5'($urandom); vb.rs2 = 5'($urandom);
         vb.f3  = 3'($urandom); vb.f7  = 7'($urandom); vb.imm = rand_imm();
         set_req(vb);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         cnt_clr   = ($urandom_range(0, 99) == 0);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
      repeat (4) tick();
      chk("final_drain", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
